cache_set_ram: RTL and testbench

N-way set-associative storage array for the data cache: per-way tag/status and line-data block RAMs, with a one-cycle tag compare, hit-way select, tree pseudo-LRU victim choice, and a hardware invalidate sweep after reset. It sits between the cache controller FSM and the block RAMs. It generalises the single-way tag and data RAM pair to WAYS ways with word-masked line writes.

---
 rtl/cache_ram_pkg.sv | 37 +++
 rtl/cache_way_bank.sv | 69 ++++++
 rtl/cache_set_ram.sv | 238 +++++++++++++++++++++++
 tb/tb_cache_set_ram.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ram_pkg.sv
// Shared definitions for the set-associative cache storage array:
// status bit positions, line geometry, a clog2 helper and the FSM encoding.
package cache_ram_pkg;

    localparam int ST_VALID = 0;
    localparam int ST_DIRTY = 1;
    localparam int ST_W     = 3;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // Number of 32-bit words in a line for a given byte-offset width.
    function automatic int words_of(input int offset_len);
        return 1 << (offset_len - 2);
    endfunction

    // Line width in bits for a given byte-offset width.
    function automatic int line_w_of(input int offset_len);
        return 32 * words_of(offset_len);
    endfunction

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/cache_way_bank.sv
// One way of the cache array: a tag/status block RAM and a line-data block RAM
// with per-word write enables. Reads are registered (one-cycle block RAM read).
// When CACHE_SET_RAM_SWEEP_EN is undefined the tag/status RAM carries a
// zero power-up image instead of being cleared by the sweep.
module cache_way_bank
    import cache_ram_pkg::*;
#(
    parameter  int TAG_LEN    = 13,
    parameter  int INDEX_LEN  = 10,
    parameter  int OFFSET_LEN = 4,
    localparam int WORDS      = words_of(OFFSET_LEN),
    localparam int LINE_W     = line_w_of(OFFSET_LEN)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [INDEX_LEN-1:0] index,
    input  logic [TAG_LEN-1:0]   wr_tag,
    input  logic [ST_W-1:0]      wr_status,
    input  logic [LINE_W-1:0]    wr_data,
    input  logic [WORDS-1:0]     wr_mask,
    output logic [TAG_LEN-1:0]   rd_tag,
    output logic [ST_W-1:0]      rd_status,
    output logic [LINE_W-1:0]    rd_data
);

    localparam int SETS = 1 << INDEX_LEN;

    typedef struct packed {
        logic [ST_W-1:0]    status;
        logic [TAG_LEN-1:0] tag;
    } ts_entry_t;

    // NOTE: RAM arrays have no reset; status is cleared by the sweep (or the
    // power-up image), which keeps them mappable onto block RAM.
`ifdef CACHE_SET_RAM_SWEEP_EN
    ts_entry_t ts_mem [SETS];
`else
    ts_entry_t ts_mem [SETS] = '{default: '0};
`endif
    logic [LINE_W-1:0] data_mem [SETS];
    ts_entry_t         rd_ts;

    // Tag/status RAM: full-entry write, registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ts_mem[index] <= '{status: wr_status, tag: wr_tag};
        end
        if (rd_en) begin
            rd_ts <= ts_mem[index];
        end
    end

    // Data RAM: per-word write enables, registered read.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WORDS; w++) begin
            if (wr_en && wr_mask[w]) begin
                data_mem[index][w*32 +: 32] <= wr_data[w*32 +: 32];
            end
        end
        if (rd_en) begin
            rd_data <= data_mem[index];
        end
    end

    assign rd_tag    = rd_ts.tag;
    assign rd_status = rd_ts.status;

endmodule

// File: rtl/cache_set_ram.sv
// N-way set-associative storage array: per-way tag/status/data banks, a
// one-cycle tag compare, hit-way select, tree pseudo-LRU victim choice and a
// post-reset invalidate sweep. Define CACHE_SET_RAM_SWEEP_EN to build the
// sweep; without it the status and PLRU arrays rely on a zero power-up image.
module cache_set_ram
    import cache_ram_pkg::*;
#(
    parameter  int TAG_LEN    = 13,
    parameter  int INDEX_LEN  = 10,
    parameter  int OFFSET_LEN = 4,
    parameter  int WAYS       = 2,
    localparam int WORDS      = words_of(OFFSET_LEN),
    localparam int LINE_W     = line_w_of(OFFSET_LEN),
    localparam int WAY_W      = (clog2(WAYS) > 0) ? clog2(WAYS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [INDEX_LEN-1:0] req_index,
    input  logic [TAG_LEN-1:0]   req_tag,
    input  logic [WAY_W-1:0]     req_way,
    input  logic [ST_W-1:0]      req_status,
    input  logic [LINE_W-1:0]    req_data,
    input  logic [WORDS-1:0]     req_wmask,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [WAY_W-1:0]     resp_way,
    output logic [TAG_LEN-1:0]   resp_tag,
    output logic [ST_W-1:0]      resp_status,
    output logic [LINE_W-1:0]    resp_data
);

    localparam int SETS   = 1 << INDEX_LEN;
    localparam int LVLS   = clog2(WAYS);
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    // Tree PLRU bits are heap-ordered (node n has children 2n+1, 2n+2); a bit
    // of 0 points the victim at the lower half, 1 at the upper half.
    // NOTE: blocking assignments are correct here: functions compute a value
    // step by step and hold no state.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] p;
        int w;
        int l;
        int pos;
        p = bits;
        w = int'(way);
        for (int n = 0; n < WAYS - 1; n++) begin
            l   = clog2(n + 2) - 1;
            pos = n + 1 - (1 << l);
            if ((w >> (LVLS - l)) == pos) begin
                p[n] = (((w >> (LVLS - 1 - l)) & 1) == 0);
            end
        end
        return p;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int v;
        int node;
        v = 0;
        for (int l = 0; l < LVLS; l++) begin
            node = (1 << l) - 1 + v;
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == node) begin
                    v = 2 * v + int'(bits[n]);
                end
            end
        end
        return WAY_W'(v);
    endfunction

    state_t                 state;
    logic                   sweeping;
    logic [INDEX_LEN-1:0]   sweep_idx;

    logic                   acc;
    logic                   wr_acc;
    logic                   rd_acc;

    logic                   lk_v;
    logic [INDEX_LEN-1:0]   idx_q;
    logic [TAG_LEN-1:0]     tag_q;

    logic [TAG_LEN-1:0]     rd_tag    [WAYS];
    logic [ST_W-1:0]        rd_status [WAYS];
    logic [LINE_W-1:0]      rd_data   [WAYS];

    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic                   inv_found;
    logic [WAY_W-1:0]       inv_way;
    logic [WAY_W-1:0]       sel_way;
    logic                   hit_upd;
    logic [PLRU_W-1:0]      plru_wr_base;

`ifdef CACHE_SET_RAM_SWEEP_EN
    logic [PLRU_W-1:0]      plru [SETS];
    state_t                 state_next;

    // FSM state register and sweep counter; reset restarts the sweep at 0.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= SWEEP;
            sweep_idx <= '0;
        end else begin
            state <= state_next;
            if (state == SWEEP) begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    // Next state: leave SWEEP once the last index has been cleared.
    always_comb begin
        state_next = state;
        case (state)
            SWEEP:   if (&sweep_idx) state_next = IDLE;
            IDLE:    state_next = IDLE;
            default: state_next = SWEEP;
        endcase
    end

    assign sweeping = rstn && (state == SWEEP);
`else
    logic [PLRU_W-1:0]      plru [SETS] = '{default: '0};

    assign state     = IDLE;
    assign sweeping  = 1'b0;
    assign sweep_idx = '0;
`endif

    assign req_ready = rstn && (state == IDLE);
    assign acc       = req_valid && req_ready;
    assign wr_acc    = acc && req_we;
    assign rd_acc    = acc && !req_we;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way_bank #(
            .TAG_LEN    (TAG_LEN),
            .INDEX_LEN  (INDEX_LEN),
            .OFFSET_LEN (OFFSET_LEN)
        ) u_bank (
            .clk       (clk),
            .wr_en     (sweeping || (wr_acc && ((WAYS == 1) || (req_way == WAY_W'(g))))),
            .rd_en     (rd_acc),
            .index     (sweeping ? sweep_idx : req_index),
            .wr_tag    (sweeping ? '0 : req_tag),
            .wr_status (sweeping ? '0 : req_status),
            .wr_data   (req_data),
            .wr_mask   (sweeping ? '0 : req_wmask),
            .rd_tag    (rd_tag[g]),
            .rd_status (rd_status[g]),
            .rd_data   (rd_data[g])
        );
    end

    // Lookup stage 1 valid; cleared by reset so an in-flight lookup is dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lk_v <= 1'b0;
        end else begin
            lk_v <= rd_acc;
        end
    end

    // Lookup stage 1 address/tag, aligned with the bank read data.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            idx_q <= req_index;
            tag_q <= req_tag;
        end
    end

    // Tag compare, lowest-way priority, lowest invalid way, then PLRU victim.
    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && rd_status[w][ST_VALID] && (rd_tag[w] == tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !rd_status[w][ST_VALID]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        sel_way      = hit ? hit_way : (inv_found ? inv_way : plru_victim(plru[idx_q]));
        hit_upd      = rstn && lk_v && hit;
        plru_wr_base = (hit_upd && (idx_q == req_index)) ? plru_touch(plru[idx_q], hit_way)
                                                         : plru[req_index];
    end

    // PLRU: cleared by the sweep, touched by lookup hits and by writes; a
    // write to the set just hit builds on the hit's update.
    always_ff @(posedge clk) begin
        if (sweeping) begin
            plru[sweep_idx] <= '0;
        end else begin
            if (hit_upd) begin
                plru[idx_q] <= plru_touch(plru[idx_q], hit_way);
            end
            if (wr_acc) begin
                plru[req_index] <= plru_touch(plru_wr_base, req_way);
            end
        end
    end

    // Response registers: one-cycle pulse, contents of the selected way.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_way    <= '0;
            resp_tag    <= '0;
            resp_status <= '0;
            resp_data   <= '0;
        end else begin
            resp_valid <= lk_v;
            if (lk_v) begin
                resp_hit    <= hit;
                resp_way    <= sel_way;
                resp_tag    <= rd_tag[sel_way];
                resp_status <= rd_status[sel_way];
                resp_data   <= rd_data[sel_way];
            end
        end
    end

endmodule

// File: tb/tb_cache_set_ram.sv
// Directed bench for cache_set_ram (WAYS=2, INDEX_LEN=4). Builds with or
// without CACHE_SET_RAM_SWEEP_EN; the reset/sweep steps follow the build.
module tb_cache_set_ram;

    localparam int TAG_LEN    = 13;
    localparam int INDEX_LEN  = 4;
    localparam int OFFSET_LEN = 4;
    localparam int WAYS       = 2;
    localparam int WORDS      = 4;
    localparam int LINE_W     = 128;
    localparam int WAY_W      = 1;

    logic                 clk;
    logic                 rstn;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [INDEX_LEN-1:0] req_index;
    logic [TAG_LEN-1:0]   req_tag;
    logic [WAY_W-1:0]     req_way;
    logic [2:0]           req_status;
    logic [LINE_W-1:0]    req_data;
    logic [WORDS-1:0]     req_wmask;
    logic                 resp_valid;
    logic                 resp_hit;
    logic [WAY_W-1:0]     resp_way;
    logic [TAG_LEN-1:0]   resp_tag;
    logic [2:0]           resp_status;
    logic [LINE_W-1:0]    resp_data;

    int total = 0;
    int bad   = 0;

    localparam logic [LINE_W-1:0] D1   = {4{32'h11111111}};
    localparam logic [LINE_W-1:0] D2   = {4{32'h22222222}};
    localparam logic [LINE_W-1:0] DMIX = {32'h11111111, 32'h22222222, 32'h11111111, 32'h11111111};
    localparam logic [LINE_W-1:0] DA   = {4{32'hA0A0A0A0}};
    localparam logic [LINE_W-1:0] DB   = {4{32'hB0B0B0B0}};
    localparam logic [LINE_W-1:0] DC   = {4{32'hC0C0C0C0}};
    localparam logic [LINE_W-1:0] DD   = {4{32'hD0D0D0D0}};
    localparam logic [LINE_W-1:0] DE   = {4{32'hE0E0E0E0}};
    localparam logic [LINE_W-1:0] DF   = {4{32'hF0F0F0F0}};

    cache_set_ram #(
        .TAG_LEN    (TAG_LEN),
        .INDEX_LEN  (INDEX_LEN),
        .OFFSET_LEN (OFFSET_LEN),
        .WAYS       (WAYS)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_index   (req_index),
        .req_tag     (req_tag),
        .req_way     (req_way),
        .req_status  (req_status),
        .req_data    (req_data),
        .req_wmask   (req_wmask),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_way    (resp_way),
        .resp_tag    (resp_tag),
        .resp_status (resp_status),
        .resp_data   (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h required=%0h", name, obs, exp);
        end
    endtask

    task automatic cyc_write(input logic [INDEX_LEN-1:0] idx, input logic [TAG_LEN-1:0] tag,
                             input logic [WAY_W-1:0] way, input logic [2:0] st,
                             input logic [LINE_W-1:0] data, input logic [WORDS-1:0] mask);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_index  = idx;
        req_tag    = tag;
        req_way    = way;
        req_status = st;
        req_data   = data;
        req_wmask  = mask;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_lookup(input logic [INDEX_LEN-1:0] idx, input logic [TAG_LEN-1:0] tag);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_index = idx;
        req_tag   = tag;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input string name, input logic hit, input logic [WAY_W-1:0] way,
                               input logic [TAG_LEN-1:0] tag, input logic [2:0] st,
                               input logic [LINE_W-1:0] data);
        check({name, "_valid"},  resp_valid, 1'b1);
        check({name, "_hit"},    resp_hit, hit);
        check({name, "_way"},    resp_way, way);
        check({name, "_tag"},    resp_tag, tag);
        check({name, "_status"}, resp_status, st);
        check({name, "_data"},   resp_data, data);
    endtask

    // Count cycles from the current point until req_ready rises (bounded);
    // resp_valid must stay low throughout.
    task automatic wait_ready(input int exp_cycles, input string name);
        int n;
        n = 0;
        check({name, "_ready_low"}, req_ready, 1'b0);
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            check({name, "_no_resp"}, resp_valid, 1'b0);
        end
        check({name, "_cycles"}, n, exp_cycles);
    endtask

    initial begin
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_index  = '0;
        req_tag    = '0;
        req_way    = '0;
        req_status = '0;
        req_data   = '0;
        req_wmask  = '0;

        // Reset state of every output.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  req_ready, 1'b0);
        check("rst_valid",  resp_valid, 1'b0);
        check("rst_hit",    resp_hit, 1'b0);
        check("rst_way",    resp_way, 1'b0);
        check("rst_tag",    resp_tag, 13'h0);
        check("rst_status", resp_status, 3'h0);
        check("rst_data",   resp_data, 128'h0);

        @(negedge clk);
        rstn = 1'b1;
`ifdef CACHE_SET_RAM_SWEEP_EN
        wait_ready(16, "sweep");
`else
        #1;
        check("ready_at_release", req_ready, 1'b1);
`endif

        // Back-to-back lookups over every set: all miss to way 0.
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                req_valid = 1'b1;
                req_we    = 1'b0;
                req_index = INDEX_LEN'(i);
                req_tag   = '0;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i > 0) begin
                check("scan_valid", resp_valid, 1'b1);
                check("scan_hit",   resp_hit, 1'b0);
                check("scan_way",   resp_way, 1'b0);
            end
        end

        // Write way1 then look up on the very next cycle.
        cyc_write(4'd5, 13'h0AB, 1'b1, 3'b001, D1, 4'b1111);
        cyc_lookup(4'd5, 13'h0AB);
        check("write_no_resp", resp_valid, 1'b0);
        cyc_idle();
        expect_resp("wr_hit", 1'b1, 1'b1, 13'h0AB, 3'b001, D1);

        // Masked write changes only word 2.
        cyc_write(4'd5, 13'h0AB, 1'b1, 3'b001, D2, 4'b0100);
        cyc_lookup(4'd5, 13'h0AB);
        cyc_idle();
        expect_resp("mask", 1'b1, 1'b1, 13'h0AB, 3'b001, DMIX);

        // PLRU victim selection at index 7 with both ways valid.
        cyc_write(4'd7, 13'h001, 1'b0, 3'b001, DA, 4'b1111);
        cyc_write(4'd7, 13'h002, 1'b1, 3'b011, DB, 4'b1111);
        cyc_lookup(4'd7, 13'h001);
        cyc_lookup(4'd7, 13'h003);
        expect_resp("plru_hit0", 1'b1, 1'b0, 13'h001, 3'b001, DA);
        cyc_lookup(4'd7, 13'h002);
        expect_resp("plru_miss_v1", 1'b0, 1'b1, 13'h002, 3'b011, DB);
        cyc_lookup(4'd7, 13'h003);
        expect_resp("plru_hit1", 1'b1, 1'b1, 13'h002, 3'b011, DB);
        cyc_idle();
        expect_resp("plru_miss_v0", 1'b0, 1'b0, 13'h001, 3'b001, DA);

        // Matching tag on an invalid way is a miss that selects that way.
        cyc_write(4'd9, 13'h044, 1'b0, 3'b001, DC, 4'b1111);
        cyc_write(4'd9, 13'h055, 1'b1, 3'b010, DD, 4'b1111);
        cyc_lookup(4'd9, 13'h055);
        cyc_idle();
        expect_resp("inv_match", 1'b0, 1'b1, 13'h055, 3'b010, DD);

        // Two valid ways with the same tag: the lowest way wins.
        cyc_write(4'd11, 13'h0CC, 1'b0, 3'b001, DE, 4'b1111);
        cyc_write(4'd11, 13'h0CC, 1'b1, 3'b001, DF, 4'b1111);
        cyc_lookup(4'd11, 13'h0CC);
        cyc_idle();
        expect_resp("multi_low", 1'b1, 1'b0, 13'h0CC, 3'b001, DE);

        // Reset drops an in-flight lookup; a write offered during reset is ignored.
        cyc_lookup(4'd5, 13'h0AB);
        @(negedge clk);
        rstn       = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_index  = 4'd13;
        req_tag    = 13'h077;
        req_way    = 1'b0;
        req_status = 3'b001;
        req_wmask  = 4'b1111;
        @(posedge clk);
        #1;
        check("rst_discard_valid", resp_valid, 1'b0);
        check("rst_discard_hit",   resp_hit, 1'b0);
        check("rst_discard_ready", req_ready, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;

`ifdef CACHE_SET_RAM_SWEEP_EN
        // Release, run 9 sweep cycles with a lookup held (ignored), pulse reset.
        rstn      = 1'b1;
        req_valid = 1'b1;
        req_index = 4'd5;
        req_tag   = 13'h0AB;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            check("midsweep_ready", req_ready, 1'b0);
            check("midsweep_valid", resp_valid, 1'b0);
        end
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        wait_ready(16, "resweep");
        cyc_lookup(4'd5, 13'h0AB);
        cyc_idle();
        check("swept_valid",  resp_valid, 1'b1);
        check("swept_hit",    resp_hit, 1'b0);
        check("swept_way",    resp_way, 1'b0);
        check("swept_status", resp_status, 3'b000);
`else
        // No sweep: ready returns at once and contents survive reset.
        rstn = 1'b1;
        #1;
        check("rerelease_ready", req_ready, 1'b1);
        cyc_lookup(4'd5, 13'h0AB);
        cyc_idle();
        expect_resp("keep_after_rst", 1'b1, 1'b1, 13'h0AB, 3'b001, DMIX);
`endif

        // The write offered during reset must not have landed.
        cyc_lookup(4'd13, 13'h077);
        cyc_idle();
        check("ignored_wr_valid", resp_valid, 1'b1);
        check("ignored_wr_hit",   resp_hit, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
